// File: rtl/cgra2_2.sv
`default_nettype none
// ============================================================================
// Module      : cgra2_2
// Description : 2x2 coarse-grained reconfigurable array. Every PE holds a
//               16-bit config word and an 8-bit data register. All of this
//               state sits in a single 96-bit scan register that is reached
//               serially through a JTAG-style scan chain.
//
//               Scan register layout:
//                 [95:80] PE00 cfg   [79:64] PE01 cfg
//                 [63:48] PE10 cfg   [47:32] PE11 cfg
//                 [31:24] PE00 data  [23:16] PE01 data
//                 [15: 8] PE10 data  [ 7: 0] PE11 data
//
//               Config word layout:
//                 [15:12] opcode  [11:10] srcA  [9:8] srcB  [7:0] imm
//
// Ports       : clk           - single clock, rising-edge active
//               rst           - synchronous active-high reset, clears all state
//               program_mode  - 1 = shift the scan chain, 0 = run the array
//               jtag_data_in  - serial scan input, enters at bit 0
//               jtag_data_out - serial scan output, the registered bit 95
// Revision    : 1.0 - initial release
// ============================================================================
module cgra2_2 (
    input  logic clk,
    input  logic rst,
    input  logic program_mode,
    input  logic jtag_data_in,
    output logic jtag_data_out
);

    localparam int c_NUM_PE   = 4;
    localparam int c_SCAN_W   = 96;
    localparam int c_DATA_W   = 8;
    localparam int c_CFG_W    = 16;

    // Opcodes
    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_SHL  = 4'd6;
    localparam logic [3:0] c_OP_SHR  = 4'd7;
    localparam logic [3:0] c_OP_MUL  = 4'd8;
    localparam logic [3:0] c_OP_PASS = 4'd9;
    localparam logic [3:0] c_OP_MIN  = 4'd10;
    localparam logic [3:0] c_OP_MAX  = 4'd11;
    localparam logic [3:0] c_OP_EQ   = 4'd12;
    localparam logic [3:0] c_OP_LT   = 4'd13;
    localparam logic [3:0] c_OP_NOT  = 4'd14;
    localparam logic [3:0] c_OP_ACC  = 4'd15;

    // Source selects
    localparam logic [1:0] c_SRC_OWN = 2'd0;
    localparam logic [1:0] c_SRC_HOR = 2'd1;
    localparam logic [1:0] c_SRC_VER = 2'd2;
    localparam logic [1:0] c_SRC_IMM = 2'd3;

    logic [c_SCAN_W-1:0]          r_scan;
    logic [c_CFG_W-1:0]           w_cfg  [c_NUM_PE];
    logic [c_DATA_W-1:0]          w_data [c_NUM_PE];
    // Next data for all four PEs, packed in the same order as r_scan[31:0]
    logic [c_NUM_PE*c_DATA_W-1:0] w_next_data;

    // ------------------------------------------------------------------------
    // 8-bit unsigned ALU. Every result wraps modulo 256.
    // ------------------------------------------------------------------------
    function automatic logic [c_DATA_W-1:0] f_alu(
        input logic [3:0]          op,
        input logic [c_DATA_W-1:0] own,
        input logic [c_DATA_W-1:0] a,
        input logic [c_DATA_W-1:0] b
    );
        logic [2*c_DATA_W-1:0] w_prod;
        logic [c_DATA_W-1:0]   w_res;
        w_prod = a * b;
        w_res  = own;
        case (op)
            c_OP_NOP:  w_res = own;
            c_OP_ADD:  w_res = a + b;
            c_OP_SUB:  w_res = a - b;
            c_OP_AND:  w_res = a & b;
            c_OP_OR:   w_res = a | b;
            c_OP_XOR:  w_res = a ^ b;
            c_OP_SHL:  w_res = a << b[2:0];
            c_OP_SHR:  w_res = a >> b[2:0];
            c_OP_MUL:  w_res = w_prod[c_DATA_W-1:0];
            c_OP_PASS: w_res = a;
            c_OP_MIN:  w_res = (a < b) ? a : b;
            c_OP_MAX:  w_res = (a > b) ? a : b;
            c_OP_EQ:   w_res = {{(c_DATA_W-1){1'b0}}, (a == b)};
            c_OP_LT:   w_res = {{(c_DATA_W-1){1'b0}}, (a < b)};
            c_OP_NOT:  w_res = ~a;
            c_OP_ACC:  w_res = own + a;
            default:   w_res = own;
        endcase
        return w_res;
    endfunction

    // ------------------------------------------------------------------------
    // Per-PE datapath. PE index p = {row, col}, so the horizontal neighbour
    // is p^1 (flip column) and the vertical neighbour is p^2 (flip row).
    // Every PE reads only pre-edge register values, so all four update
    // together without ordering effects.
    // ------------------------------------------------------------------------
    generate
        for (genvar p = 0; p < c_NUM_PE; p++) begin : g_pe
            localparam int c_HOR = p ^ 1;
            localparam int c_VER = p ^ 2;

            logic [c_DATA_W-1:0] w_a;
            logic [c_DATA_W-1:0] w_b;
            logic [c_DATA_W-1:0] w_imm;

            assign w_cfg[p]  = r_scan[c_SCAN_W-1-c_CFG_W*p -: c_CFG_W];
            assign w_data[p] = r_scan[c_NUM_PE*c_DATA_W-1-c_DATA_W*p -: c_DATA_W];
            assign w_imm     = w_cfg[p][7:0];

            always_comb begin
                w_a = w_data[p];
                case (w_cfg[p][11:10])
                    c_SRC_OWN: w_a = w_data[p];
                    c_SRC_HOR: w_a = w_data[c_HOR];
                    c_SRC_VER: w_a = w_data[c_VER];
                    c_SRC_IMM: w_a = w_imm;
                    default:   w_a = w_data[p];
                endcase
            end

            always_comb begin
                w_b = w_data[p];
                case (w_cfg[p][9:8])
                    c_SRC_OWN: w_b = w_data[p];
                    c_SRC_HOR: w_b = w_data[c_HOR];
                    c_SRC_VER: w_b = w_data[c_VER];
                    c_SRC_IMM: w_b = w_imm;
                    default:   w_b = w_data[p];
                endcase
            end

            assign w_next_data[c_NUM_PE*c_DATA_W-1-c_DATA_W*p -: c_DATA_W] =
                f_alu(w_cfg[p][15:12], w_data[p], w_a, w_b);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Scan / run register. Reset wins over both modes. In program mode the
    // whole register shifts MSB-first; in run mode the config half is held
    // and only the data half takes the freshly computed values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= '0;
        end else if (program_mode) begin
            r_scan <= {r_scan[c_SCAN_W-2:0], jtag_data_in};
        end else begin
            r_scan <= {r_scan[c_SCAN_W-1:c_NUM_PE*c_DATA_W], w_next_data};
        end
    end

    // Output comes straight from a flop, so there is no combinational path
    // from jtag_data_in.
    assign jtag_data_out = r_scan[c_SCAN_W-1];

endmodule
`default_nettype wire

// File: tb/tb_cgra2_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_cgra2_2
// Description : Self-checking bench for cgra2_2. Scan images are loaded
//               serially, the array runs for a fixed number of cycles, and
//               the image is shifted back out and compared field by field.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cgra2_2;

    logic clk;
    logic rst;
    logic program_mode;
    logic jtag_data_in;
    logic jtag_data_out;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       name;
        logic [63:0] cfgs;    // {PE00, PE01, PE10, PE11} config
        logic [31:0] data;    // {PE00, PE01, PE10, PE11} initial data
        int          cycles;  // run-mode cycles
        logic [31:0] exp;     // expected data after running
    } vec_t;

    vec_t        vecs[8];
    logic [95:0] sb_q[$];

    cgra2_2 u_dut (
        .clk           (clk),
        .rst           (rst),
        .program_mode  (program_mode),
        .jtag_data_in  (jtag_data_in),
        .jtag_data_out (jtag_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts v in MSB-first while capturing the previous image as it leaves.
    task automatic xfer(input logic [95:0] v, output logic [95:0] old);
        for (int k = 0; k < 96; k++) begin
            old[95-k]    = jtag_data_out;
            program_mode = 1'b1;
            jtag_data_in = v[95-k];
            tick();
        end
    endtask

    task automatic run(input int n);
        program_mode = 1'b0;
        jtag_data_in = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [95:0] got;
        logic [95:0] exp;
        logic [95:0] dummy;
        logic [9:0]  run_out;
        logic [99:0] lat_got;
        logic [99:0] lat_exp;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{"counter",   64'h1C01_0000_0000_0000, 32'h00000000, 5, 32'h05000000};
        vecs[1] = '{"routing",   64'h0000_9400_9800_0000, 32'h12000000, 1, 32'h12121200};
        vecs[2] = '{"wrap",      64'h1CFF_0000_0000_0000, 32'h02000000, 1, 32'h01000000};
        vecs[3] = '{"sub_logic", 64'h2100_3100_4200_53FF, 32'h5A3CF00F, 1, 32'h1E18FAF0};
        vecs[4] = '{"shift_mul", 64'h6100_7309_8200_9400, 32'h81030710, 1, 32'h08018707};
        vecs[5] = '{"min_max",   64'hA100_B200_C200_D100, 32'h40204090, 1, 32'h20900100};
        vecs[6] = '{"not_acc",   64'hE000_F800_D304_C3FF, 32'h0F0503FE, 1, 32'hF0030100};
        vecs[7] = '{"swap_2cyc", 64'h2100_9400_0000_0000, 32'h0102AA55, 2, 32'hFEFFAA55};

        rst          = 1'b1;
        program_mode = 1'b0;
        jtag_data_in = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state, then idle running keeps everything at zero
        check("reset_out", {95'd0, jtag_data_out}, 96'd0);
        for (int k = 0; k < 10; k++) begin
            program_mode = 1'b0;
            tick();
            run_out[k] = jtag_data_out;
        end
        check("reset_run_out", {86'd0, run_out}, 96'd0);
        xfer(96'd0, got);
        check("reset_scan", got, 96'd0);

        // Shift latency: a single 1 emerges exactly 96 edges after it is sampled
        lat_exp = '0;
        lat_exp[95] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            program_mode = 1'b1;
            jtag_data_in = (k == 0);
            tick();
            lat_got[k] = jtag_data_out;
        end
        check("shift_latency", {(96-4)'(0), 4'd0} | 96'(lat_got[99:4]), 96'(lat_exp[99:4]));
        check("shift_latency_lo", 96'(lat_got[3:0]), 96'(lat_exp[3:0]));

        // Table of program / run / read-back vectors
        for (int i = 0; i < 8; i++) begin
            xfer({vecs[i].cfgs, vecs[i].data}, dummy);
            run(vecs[i].cycles);
            sb_q.push_back({vecs[i].cfgs, vecs[i].exp});
            xfer(96'd0, got);
            exp = sb_q.pop_front();
            check({vecs[i].name, "_cfg"},  96'(got[95:32]), 96'(exp[95:32]));
            check({vecs[i].name, "_pe00"}, 96'(got[31:24]), 96'(exp[31:24]));
            check({vecs[i].name, "_pe01"}, 96'(got[23:16]), 96'(exp[23:16]));
            check({vecs[i].name, "_pe10"}, 96'(got[15:8]),  96'(exp[15:8]));
            check({vecs[i].name, "_pe11"}, 96'(got[7:0]),   96'(exp[7:0]));
        end

        // Reset in the middle of a shift
        xfer({vecs[4].cfgs, vecs[4].data}, dummy);
        for (int k = 0; k < 40; k++) begin
            program_mode = 1'b1;
            jtag_data_in = 1'b1;
            tick();
        end
        jtag_data_in = 1'b1;
        pulse_reset();
        check("midshift_rst_out", {95'd0, jtag_data_out}, 96'd0);
        xfer(96'd0, got);
        check("midshift_rst_scan", got, 96'd0);

        // Reset in the middle of a run; afterwards every PE is NOP at zero
        xfer({vecs[0].cfgs, vecs[0].data}, dummy);
        run(3);
        program_mode = 1'b0;
        pulse_reset();
        run(4);
        xfer(96'd0, got);
        check("midrun_rst_scan", got, 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
